i2c_txn_arbiter: RTL and testbench

Transaction scheduler between the AXI-Lite slave front end and the I2C master engine. Queues write and read requests arriving from the AXI slave in two small FIFOs, arbitrates them round-robin onto the single I2C master, and sequences each transfer: issue, wait for completion, return response. Status outputs drive the slave's pending-transaction flags, so the bus side can accept new requests while an I2C transfer is in flight.

---
 rtl/i2c_txn_arbiter.sv | 176 +++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
// Round-robin scheduler of queued write/read requests onto a single I2C master.
// Optional WAIT watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter #(
    parameter int unsigned WDATA_W     = 16,
    parameter int unsigned RDATA_W     = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               WR_REQ_VALID,
    output logic               WR_REQ_READY,
    input  logic [WDATA_W-1:0] WR_REQ_DATA,
    input  logic               RD_REQ_VALID,
    output logic               RD_REQ_READY,
    input  logic [7:0]         RD_REQ_ADDR,
    output logic               WR_RSP_VALID,
    input  logic               WR_RSP_READY,
    output logic               WR_RSP_ERR,
    output logic               RD_RSP_VALID,
    input  logic               RD_RSP_READY,
    output logic [RDATA_W-1:0] RD_RSP_DATA,
    output logic               RD_RSP_ERR,
    output logic               I2C_TRIGGER,
    output logic               I2C_RW,
    output logic [WDATA_W-1:0] I2C_ADDR_DATA,
    input  logic               I2C_BUSY,
    input  logic               I2C_DONE,
    input  logic               I2C_ACK_ERR,
    input  logic [RDATA_W-1:0] I2C_RDATA,
    output logic               PENDING_WR,
    output logic               PENDING_RD
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t               state_q;
    logic [WDATA_W-1:0]   wr_mem_q [FIFO_DEPTH];
    logic [7:0]           rd_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_wp_q, wr_rp_q, rd_wp_q, rd_rp_q;
    logic [CNT_W-1:0]     wr_cnt_q, rd_cnt_q, wr_cnt_d, rd_cnt_d;
    logic                 wr_rdy_q, rd_rdy_q;
    logic                 last_rd_q, trig_q, rw_q;
    logic [WDATA_W-1:0]   cmd_q;
    logic                 wr_vld_q, rd_vld_q, wr_err_q, rd_err_q;
    logic [RDATA_W-1:0]   rd_data_q;

    logic wr_push, rd_push, wr_pop, rd_pop;
    logic wr_ne, rd_ne, start, grant_rd;
    logic tmo_hit, wait_end, end_err;
    logic [RDATA_W-1:0] end_data;

    assign wr_push  = WR_REQ_VALID & wr_rdy_q;
    assign rd_push  = RD_REQ_VALID & rd_rdy_q;
    assign wr_ne    = (wr_cnt_q != '0);
    assign rd_ne    = (rd_cnt_q != '0);
    assign start    = (state_q == S_IDLE) && (wr_ne || rd_ne) && !I2C_BUSY;
    // On a tie the side not granted last time wins.
    assign grant_rd = rd_ne && (!wr_ne || !last_rd_q);
    assign wr_pop   = start & ~grant_rd;
    assign rd_pop   = start & grant_rd;
    assign wr_cnt_d = wr_cnt_q + CNT_W'(wr_push) - CNT_W'(wr_pop);
    assign rd_cnt_d = rd_cnt_q + CNT_W'(rd_push) - CNT_W'(rd_pop);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_wp_q  <= '0;
            wr_rp_q  <= '0;
            rd_wp_q  <= '0;
            rd_rp_q  <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            wr_rdy_q <= 1'b0;
            rd_rdy_q <= 1'b0;
        end else begin
            if (wr_push) begin
                wr_mem_q[wr_wp_q] <= WR_REQ_DATA;
                wr_wp_q           <= wr_wp_q + PTR_W'(1);
            end
            if (rd_push) begin
                rd_mem_q[rd_wp_q] <= RD_REQ_ADDR;
                rd_wp_q           <= rd_wp_q + PTR_W'(1);
            end
            if (wr_pop) wr_rp_q <= wr_rp_q + PTR_W'(1);
            if (rd_pop) rd_rp_q <= rd_rp_q + PTR_W'(1);
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            wr_rdy_q <= (wr_cnt_d != CNT_W'(FIFO_DEPTH));
            rd_rdy_q <= (rd_cnt_d != CNT_W'(FIFO_DEPTH));
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TMO_W-1:0] tmo_q;

    always_ff @(posedge ACLK) begin
        if (ARESET || state_q != S_WAIT) tmo_q <= '0;
        else                             tmo_q <= tmo_q + TMO_W'(1);
    end
    assign tmo_hit = (state_q == S_WAIT) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
    localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
    assign tmo_hit = 1'b0;
`endif

    // DONE takes priority over a watchdog expiry in the same cycle.
    assign wait_end = I2C_DONE | tmo_hit;
    assign end_err  = I2C_DONE ? I2C_ACK_ERR : 1'b1;
    assign end_data = end_err ? '0 : I2C_RDATA;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            last_rd_q <= 1'b1;
            trig_q    <= 1'b0;
            rw_q      <= 1'b0;
            cmd_q     <= '0;
            wr_vld_q  <= 1'b0;
            rd_vld_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            trig_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    rw_q      <= grant_rd;
                    last_rd_q <= grant_rd;
                    cmd_q     <= grant_rd ? {rd_mem_q[rd_rp_q], {(WDATA_W-8){1'b0}}}
                                          : wr_mem_q[wr_rp_q];
                    trig_q    <= 1'b1;
                    state_q   <= S_ISSUE;
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: if (wait_end) begin
                    if (rw_q) begin
                        rd_vld_q  <= 1'b1;
                        rd_err_q  <= end_err;
                        rd_data_q <= end_data;
                    end else begin
                        wr_vld_q  <= 1'b1;
                        wr_err_q  <= end_err;
                    end
                    state_q <= S_RESP;
                end
                S_RESP: if ((wr_vld_q && WR_RSP_READY) || (rd_vld_q && RD_RSP_READY)) begin
                    wr_vld_q  <= 1'b0;
                    rd_vld_q  <= 1'b0;
                    wr_err_q  <= 1'b0;
                    rd_err_q  <= 1'b0;
                    rd_data_q <= '0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign WR_REQ_READY  = wr_rdy_q;
    assign RD_REQ_READY  = rd_rdy_q;
    assign WR_RSP_VALID  = wr_vld_q;
    assign WR_RSP_ERR    = wr_err_q;
    assign RD_RSP_VALID  = rd_vld_q;
    assign RD_RSP_DATA   = rd_data_q;
    assign RD_RSP_ERR    = rd_err_q;
    assign I2C_TRIGGER   = trig_q;
    assign I2C_RW        = rw_q;
    assign I2C_ADDR_DATA = cmd_q;
    assign PENDING_WR    = wr_ne;
    assign PENDING_RD    = rd_ne;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter; the watchdog step runs only when
// I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_txn_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        WR_REQ_VALID, WR_REQ_READY;
    logic [15:0] WR_REQ_DATA;
    logic        RD_REQ_VALID, RD_REQ_READY;
    logic [7:0]  RD_REQ_ADDR;
    logic        WR_RSP_VALID, WR_RSP_READY, WR_RSP_ERR;
    logic        RD_RSP_VALID, RD_RSP_READY, RD_RSP_ERR;
    logic [7:0]  RD_RSP_DATA;
    logic        I2C_TRIGGER, I2C_RW;
    logic [15:0] I2C_ADDR_DATA;
    logic        I2C_BUSY, I2C_DONE, I2C_ACK_ERR;
    logic [7:0]  I2C_RDATA;
    logic        PENDING_WR, PENDING_RD;

    int checks = 0;
    int errors = 0;
    int trig_cnt = 0;
    int exp_trig = 0;

    always #5 ACLK = ~ACLK;

    i2c_txn_arbiter #(
        .WDATA_W(16), .RDATA_W(8), .FIFO_DEPTH(4), .TIMEOUT_CYC(64)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .WR_REQ_VALID(WR_REQ_VALID), .WR_REQ_READY(WR_REQ_READY), .WR_REQ_DATA(WR_REQ_DATA),
        .RD_REQ_VALID(RD_REQ_VALID), .RD_REQ_READY(RD_REQ_READY), .RD_REQ_ADDR(RD_REQ_ADDR),
        .WR_RSP_VALID(WR_RSP_VALID), .WR_RSP_READY(WR_RSP_READY), .WR_RSP_ERR(WR_RSP_ERR),
        .RD_RSP_VALID(RD_RSP_VALID), .RD_RSP_READY(RD_RSP_READY), .RD_RSP_DATA(RD_RSP_DATA),
        .RD_RSP_ERR(RD_RSP_ERR),
        .I2C_TRIGGER(I2C_TRIGGER), .I2C_RW(I2C_RW), .I2C_ADDR_DATA(I2C_ADDR_DATA),
        .I2C_BUSY(I2C_BUSY), .I2C_DONE(I2C_DONE), .I2C_ACK_ERR(I2C_ACK_ERR),
        .I2C_RDATA(I2C_RDATA),
        .PENDING_WR(PENDING_WR), .PENDING_RD(PENDING_RD)
    );

    always @(negedge ACLK) if (I2C_TRIGGER === 1'b1) trig_cnt++;

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_trig(input string tag);
        int n = 0;
        while (I2C_TRIGGER !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(I2C_TRIGGER), 1);
    endtask

    task automatic serve(input string tag, input logic exp_rw, input logic [15:0] exp_cmd,
                         input logic [7:0] rdata, input logic ack, input int lat,
                         input logic [7:0] exp_data);
        wait_trig({tag, "_trig"});
        exp_trig++;
        chk({tag, "_rw"}, 32'(I2C_RW), 32'(exp_rw));
        chk({tag, "_cmd"}, 32'(I2C_ADDR_DATA), 32'(exp_cmd));
        I2C_BUSY = 1'b1;
        step();
        chk({tag, "_pulse"}, 32'(I2C_TRIGGER), 0);
        repeat (lat) step();
        chk({tag, "_hold_rw"}, 32'(I2C_RW), 32'(exp_rw));
        chk({tag, "_hold_cmd"}, 32'(I2C_ADDR_DATA), 32'(exp_cmd));
        I2C_DONE = 1'b1; I2C_ACK_ERR = ack; I2C_RDATA = rdata;
        step();
        I2C_DONE = 1'b0; I2C_BUSY = 1'b0; I2C_ACK_ERR = 1'b0; I2C_RDATA = 8'h00;
        if (exp_rw) begin
            chk({tag, "_rd_vld"}, 32'(RD_RSP_VALID), 1);
            chk({tag, "_wr_vld"}, 32'(WR_RSP_VALID), 0);
            chk({tag, "_rd_data"}, 32'(RD_RSP_DATA), 32'(exp_data));
            chk({tag, "_rd_err"}, 32'(RD_RSP_ERR), 32'(ack));
            RD_RSP_READY = 1'b1;
            step();
            RD_RSP_READY = 1'b0;
            chk({tag, "_rd_drop"}, 32'(RD_RSP_VALID), 0);
        end else begin
            chk({tag, "_wr_vld"}, 32'(WR_RSP_VALID), 1);
            chk({tag, "_rd_vld"}, 32'(RD_RSP_VALID), 0);
            chk({tag, "_wr_err"}, 32'(WR_RSP_ERR), 32'(ack));
            WR_RSP_READY = 1'b1;
            step();
            WR_RSP_READY = 1'b0;
            chk({tag, "_wr_drop"}, 32'(WR_RSP_VALID), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] fill [5];
        logic        seen;

        ARESET = 1'b1;
        WR_REQ_VALID = 1'b0; WR_REQ_DATA = '0; RD_REQ_VALID = 1'b0; RD_REQ_ADDR = '0;
        WR_RSP_READY = 1'b0; RD_RSP_READY = 1'b0;
        I2C_BUSY = 1'b0; I2C_DONE = 1'b0; I2C_ACK_ERR = 1'b0; I2C_RDATA = '0;

        // Reset values
        repeat (3) step();
        chk("rst_wr_ready", 32'(WR_REQ_READY), 0);
        chk("rst_rd_ready", 32'(RD_REQ_READY), 0);
        chk("rst_pending", 32'({PENDING_WR, PENDING_RD}), 0);
        chk("rst_rsp_valid", 32'({WR_RSP_VALID, RD_RSP_VALID, WR_RSP_ERR, RD_RSP_ERR}), 0);
        chk("rst_trig_rw", 32'({I2C_TRIGGER, I2C_RW}), 0);
        chk("rst_addr_data", 32'(I2C_ADDR_DATA), 0);
        chk("rst_rd_data", 32'(RD_RSP_DATA), 0);
        ARESET = 1'b0;
        chk("rst_ready_still_low", 32'(WR_REQ_READY), 0);
        step();
        chk("rst_wr_ready_rise", 32'(WR_REQ_READY), 1);
        chk("rst_rd_ready_rise", 32'(RD_REQ_READY), 1);

        // Single write with accept -> pending -> trigger timing
        WR_REQ_VALID = 1'b1; WR_REQ_DATA = 16'hA55A;
        step();
        WR_REQ_VALID = 1'b0;
        chk("w1_pending", 32'(PENDING_WR), 1);
        chk("w1_no_trig_yet", 32'(I2C_TRIGGER), 0);
        step();
        chk("w1_trig_at_grant", 32'(I2C_TRIGGER), 1);
        chk("w1_popped", 32'(PENDING_WR), 0);
        serve("w1", 1'b0, 16'hA55A, 8'h00, 1'b0, 20, 8'h00);
        chk("w1_trig_count", 32'(trig_cnt), 32'(exp_trig));

        // Fill write FIFO while master busy
        fill[0] = 16'h1001; fill[1] = 16'h2002; fill[2] = 16'h3003; fill[3] = 16'h4004;
        fill[4] = 16'hDEAD;
        I2C_BUSY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            WR_REQ_VALID = 1'b1; WR_REQ_DATA = fill[i];
            step();
        end
        WR_REQ_DATA = fill[4];
        chk("fill_full_ready", 32'(WR_REQ_READY), 0);
        step();
        WR_REQ_VALID = 1'b0;
        chk("fill_still_full", 32'(WR_REQ_READY), 0);
        chk("fill_no_trig_busy", 32'(trig_cnt), 32'(exp_trig));
        I2C_BUSY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            serve($sformatf("fill%0d", i), 1'b0, fill[i], 8'h00, 1'b0, 3, 8'h00);
            if (i == 0) chk("fill_ready_back", 32'(WR_REQ_READY), 1);
        end
        step();
        chk("fill_drained", 32'(PENDING_WR), 0);
        chk("fill_trig_count", 32'(trig_cnt), 32'(exp_trig));

        // Single read
        RD_REQ_VALID = 1'b1; RD_REQ_ADDR = 8'h3C;
        step();
        RD_REQ_VALID = 1'b0;
        chk("r1_pending", 32'(PENDING_RD), 1);
        serve("r1", 1'b1, 16'h3C00, 8'h7E, 1'b0, 6, 8'h7E);

        // Alternation W,R,W,R,W,R (last grant was a read)
        I2C_BUSY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            WR_REQ_VALID = 1'b1; WR_REQ_DATA = 16'(16'h1101 * (i + 1));
            RD_REQ_VALID = 1'b1; RD_REQ_ADDR = 8'(8'h41 + i);
            step();
        end
        WR_REQ_VALID = 1'b0; RD_REQ_VALID = 1'b0;
        chk("alt_both_pending", 32'({PENDING_WR, PENDING_RD}), 32'h3);
        I2C_BUSY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            serve($sformatf("alt_w%0d", i), 1'b0, 16'(16'h1101 * (i + 1)), 8'h00, 1'b0, 2, 8'h00);
            serve($sformatf("alt_r%0d", i), 1'b1, {8'(8'h41 + i), 8'h00}, 8'(8'h90 + i), 1'b0, 2,
                  8'(8'h90 + i));
        end

        // Read NACK with held-off response and a write queued behind it
        RD_REQ_VALID = 1'b1; RD_REQ_ADDR = 8'h55;
        step();
        RD_REQ_VALID = 1'b0;
        wait_trig("nack_trig");
        exp_trig++;
        chk("nack_cmd", 32'(I2C_ADDR_DATA), 32'h5500);
        I2C_BUSY = 1'b1;
        step();
        WR_REQ_VALID = 1'b1; WR_REQ_DATA = 16'h5A5A;
        step();
        WR_REQ_VALID = 1'b0;
        repeat (3) step();
        I2C_DONE = 1'b1; I2C_ACK_ERR = 1'b1; I2C_RDATA = 8'hFF;
        step();
        I2C_DONE = 1'b0; I2C_BUSY = 1'b0; I2C_ACK_ERR = 1'b0; I2C_RDATA = 8'h00;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (RD_RSP_VALID !== 1'b1 || RD_RSP_DATA !== 8'h00 || RD_RSP_ERR !== 1'b1) seen = 1'b1;
            step();
        end
        chk("nack_held_stable", 32'(seen), 0);
        chk("nack_rd_err", 32'(RD_RSP_ERR), 1);
        chk("nack_rd_data", 32'(RD_RSP_DATA), 0);
        chk("nack_no_new_trig", 32'(trig_cnt), 32'(exp_trig));
        chk("nack_wr_queued", 32'(PENDING_WR), 1);
        RD_RSP_READY = 1'b1;
        step();
        RD_RSP_READY = 1'b0;
        chk("nack_rd_drop", 32'(RD_RSP_VALID), 0);
        serve("nack_wr", 1'b0, 16'h5A5A, 8'h00, 1'b0, 2, 8'h00);

        // Reset while WAIT; last grant was a write so the read goes first
        WR_REQ_VALID = 1'b1; WR_REQ_DATA = 16'hBEEF;
        RD_REQ_VALID = 1'b1; RD_REQ_ADDR = 8'h66;
        step();
        RD_REQ_VALID = 1'b0; WR_REQ_DATA = 16'h1234;
        step();
        WR_REQ_VALID = 1'b0;
        chk("rstw_trig", 32'(I2C_TRIGGER), 1);
        chk("rstw_read_first", 32'(I2C_ADDR_DATA), 32'h6600);
        exp_trig++;
        I2C_BUSY = 1'b1;
        repeat (3) step();
        chk("rstw_wr_pending", 32'(PENDING_WR), 1);
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        I2C_BUSY = 1'b0;
        chk("rstw_fifos_empty", 32'({PENDING_WR, PENDING_RD}), 0);
        I2C_DONE = 1'b1; I2C_RDATA = 8'h11;
        step();
        I2C_DONE = 1'b0; I2C_RDATA = 8'h00;
        chk("rstw_ready_back", 32'({WR_REQ_READY, RD_REQ_READY}), 32'h3);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (WR_RSP_VALID !== 1'b0 || RD_RSP_VALID !== 1'b0) seen = 1'b1;
            step();
        end
        chk("rstw_no_response", 32'(seen), 0);
        chk("rstw_no_trig", 32'(trig_cnt), 32'(exp_trig));

`ifdef I2C_ARB_TIMEOUT_EN
        // Watchdog: no DONE, expiry 64 cycles after ISSUE, late DONE ignored
        WR_REQ_VALID = 1'b1; WR_REQ_DATA = 16'h0BAD;
        step();
        WR_REQ_VALID = 1'b0;
        wait_trig("tmo_trig");
        exp_trig++;
        I2C_BUSY = 1'b1;
        repeat (64) step();
        chk("tmo_not_yet", 32'(WR_RSP_VALID), 0);
        step();
        chk("tmo_valid", 32'(WR_RSP_VALID), 1);
        chk("tmo_err", 32'(WR_RSP_ERR), 1);
        I2C_BUSY = 1'b0; I2C_DONE = 1'b1;
        step();
        I2C_DONE = 1'b0;
        chk("tmo_late_done_err", 32'(WR_RSP_ERR), 1);
        WR_RSP_READY = 1'b1;
        step();
        WR_RSP_READY = 1'b0;
        chk("tmo_drop", 32'(WR_RSP_VALID), 0);
        repeat (5) step();
        chk("tmo_no_trig", 32'(trig_cnt), 32'(exp_trig));
`endif

        chk("final_trig_count", 32'(trig_cnt), 32'(exp_trig));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
